mem_block_mover: RTL

- Initiator-side engine for the single-port data memory: combinational read, write on the rising clock edge when mem_write=1.
- Copies a block of words from one memory region to another, or fills a region with a constant value.
- Owns the memory's address, write-enable and write-data inputs, and consumes its read-data output.
- Sits beside the processor datapath. Memory port arbitration is outside this block: the mover assumes exclusive access while busy=1.

---
 rtl/mem_block_mover.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_block_mover.sv
// Block copy / fill engine driving a single-port data memory.
// Ports: clk, rst_n, start/mode/src_addr/dst_addr/length/fill_value in; busy/done/err out; mem_* memory port.
module mem_block_mover #(
  parameter int AD_WD     = 16,
  parameter int DATA_WD   = 32,
  parameter int LEN_WD    = 8,
  parameter int MEM_DEPTH = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [AD_WD-1:0]   src_addr,
  input  logic [AD_WD-1:0]   dst_addr,
  input  logic [LEN_WD-1:0]  length,
  input  logic [DATA_WD-1:0] fill_value,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AD_WD-1:0]   mem_address,
  output logic               mem_write,
  output logic [DATA_WD-1:0] mem_wdata,
  input  logic [DATA_WD-1:0] mem_rdata
);

  // Range sums are one bit wider than the widest operand so they never wrap.
  localparam int EW = ((AD_WD > LEN_WD) ? AD_WD : LEN_WD) + 1;
  localparam logic [EW-1:0] DEPTH = EW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [AD_WD-1:0]   src_q, src_d;
  logic [AD_WD-1:0]   dst_q, dst_d;
  logic [LEN_WD-1:0]  cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [DATA_WD-1:0] fill_q, fill_d;
  logic [DATA_WD-1:0] buf_q, buf_d;
  logic               err_q, err_d;

  logic [EW-1:0] dst_end;
  logic [EW-1:0] src_end;
  logic          range_err;

  assign dst_end   = EW'(dst_addr) + EW'(length);
  assign src_end   = EW'(src_addr) + EW'(length);
  assign range_err = (dst_end > DEPTH) ||
                     (!mode && (src_end > DEPTH));

  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    fill_d      = fill_q;
    buf_d       = buf_q;
    err_d       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = '0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = length;
          mode_d = mode;
          fill_d = fill_value;
          if (range_err) begin
            err_d = 1'b1;
          end else if (length == '0) begin
            state_d = DONE;
          end else begin
            state_d = mode ? WR : RD;
          end
        end
      end
      RD: begin
        busy        = 1'b1;
        mem_address = src_q;
        buf_d       = mem_rdata;
        state_d     = WR;
      end
      WR: begin
        busy        = 1'b1;
        mem_address = dst_q;
        mem_write   = 1'b1;
        mem_wdata   = mode_q ? fill_q : buf_q;
        src_d       = src_q + AD_WD'(1);
        dst_d       = dst_q + AD_WD'(1);
        cnt_d       = cnt_q - LEN_WD'(1);
        if (cnt_q == LEN_WD'(1)) begin
          state_d = DONE;
        end else begin
          state_d = mode_q ? WR : RD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
